// File: rtl/ssd_debug_scan_if.sv
// rtl/ssd_debug_scan_if.sv - CPU debug taps, page button and seven-segment display signals
interface ssd_debug_scan_if;
    logic        page_btn;
    logic [15:0] pc;
    logic [15:0] insn;
    logic [3:0]  state;
    logic [7:0]  outport;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  page;

    modport master (
        output page_btn, pc, insn, state, outport,
        input  seg, an, page
    );

    modport slave (
        input  page_btn, pc, insn, state, outport,
        output seg, an, page
    );
endinterface

// File: rtl/ssd_debug_scan.sv
// rtl/ssd_debug_scan.sv - four-digit multiplexed hex debug display with page select
// Optional button debounce is built when SSD_DEBOUNCE_EN is defined.
module ssd_debug_scan #(
    parameter int PRESCALE_BITS = 15,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    ssd_debug_scan_if.slave  dbg
);

    localparam logic [1:0] PAGE_PC    = 2'd0;
    localparam logic [1:0] PAGE_INSN  = 2'd1;
    localparam logic [1:0] PAGE_STATE = 2'd2;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;

    logic [PRESCALE_BITS-1:0] prescale;
    logic [1:0]  digit;
    logic [1:0]  page_q;
    logic [1:0]  snap_page;
    logic [15:0] snapshot;
    logic [15:0] page_value;
    logic [7:0]  seg_q;
    logic [3:0]  an_q;
    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_d;
    logic        page_evt;
    logic        digit_step;
    logic        scan_wrap;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic        dp_n;

    assign digit_step = &prescale;
    assign scan_wrap  = digit_step && (digit == 2'd3);
    assign page_evt   = level && !level_d;

    always_comb begin
        page_value = {4'h0, dbg.state, dbg.outport};
        case (page_q)
            PAGE_PC:   page_value = dbg.pc;
            PAGE_INSN: page_value = dbg.insn;
            default:   page_value = {4'h0, dbg.state, dbg.outport};
        endcase
    end

    // Display path reads only the frozen snapshot so one scan shows one sample.
    always_comb begin
        nibble = snapshot[3:0];
        case (digit)
            2'd1:    nibble = snapshot[7:4];
            2'd2:    nibble = snapshot[11:8];
            2'd3:    nibble = snapshot[15:12];
            default: nibble = snapshot[3:0];
        endcase
        dp_n = (digit != snap_page);
    end

    always_comb begin
        glyph = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef SSD_DEBOUNCE_EN
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE = 1;
    logic [DEBOUNCE_BITS-1:0] db_count;
    logic                     db_level;

    // Count consecutive clocks of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (sync2 != db_level) begin
            if (&db_count) begin
                db_level <= sync2;
                db_count <= '0;
            end else begin
                db_count <= db_count + DB_ONE;
            end
        end else begin
            db_count <= '0;
        end
    end

    assign level = db_level;
`else
    logic db_unused;
    assign db_unused = (DEBOUNCE_BITS > 0);
    assign level     = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale  <= '0;
            digit     <= 2'd0;
            page_q    <= PAGE_PC;
            snapshot  <= 16'h0000;
            snap_page <= PAGE_PC;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level_d   <= 1'b0;
            seg_q     <= 8'hFF;
            an_q      <= 4'hF;
        end else begin
            prescale <= prescale + PRE_ONE;
            if (digit_step)
                digit <= digit + 2'd1;
            // page_q here is the pre-event value, so a coincident press shows next scan
            if (scan_wrap) begin
                snapshot  <= page_value;
                snap_page <= page_q;
            end
            seg_q   <= {dp_n, glyph};
            an_q    <= ~(4'b0001 << digit);
            sync1   <= dbg.page_btn;
            sync2   <= sync1;
            level_d <= level;
            if (page_evt)
                page_q <= (page_q == PAGE_STATE) ? PAGE_PC : page_q + 2'd1;
        end
    end

    assign dbg.seg  = seg_q;
    assign dbg.an   = an_q;
    assign dbg.page = page_q;

endmodule

// File: tb/tb_ssd_debug_scan.sv
// tb/tb_ssd_debug_scan.sv - self-checking bench for ssd_debug_scan
module tb_ssd_debug_scan;
    localparam int P    = 2;
    localparam int D    = 3;
    localparam int SCAN = 4 << P;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ssd_debug_scan_if bus();

    ssd_debug_scan #(.PRESCALE_BITS(P), .DEBOUNCE_BITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int              pg;
        logic [15:0]     pc;
        logic [15:0]     insn;
        logic [3:0]      st;
        logic [7:0]      op;
        logic [3:0][7:0] exp_seg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pageval(input int pg);
        case (pg)
            0:       return bus.pc;
            1:       return bus.insn;
            default: return {4'h0, bus.state, bus.outport};
        endcase
    endfunction

    // Reference model: time since reset selects the digit; snapshots every full scan.
    int          t;
    int          m_page;
    int          m_snap_page;
    logic [15:0] m_snap;
    logic        s1, s2, lvl, lvl_prev;
    int          run;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;

    always @(posedge clk) begin : model
        int   d;
        logic evt;
        if (reset) begin
            t = 0; m_page = 0; m_snap_page = 0; m_snap = 16'h0;
            s1 = 0; s2 = 0; lvl = 0; lvl_prev = 0; run = 0;
            exp_seg = 8'hFF; exp_an = 4'hF;
        end else begin
            t = t + 1;
            d = ((t - 1) / (1 << P)) % 4;
            exp_an    = 4'hF;
            exp_an[d] = 1'b0;
            exp_seg   = {(d != m_snap_page), glyph[m_snap[4*d +: 4]]};
            if (t % SCAN == 0) begin
                m_snap      = pageval(m_page);
                m_snap_page = m_page;
            end
`ifndef SSD_DEBOUNCE_EN
            lvl = s2;
`endif
            evt      = lvl && !lvl_prev;
            lvl_prev = lvl;
`ifdef SSD_DEBOUNCE_EN
            if (s2 != lvl) begin
                run = run + 1;
                if (run == (1 << D)) begin
                    lvl = s2;
                    run = 0;
                end
            end else begin
                run = 0;
            end
`endif
            s2 = s1;
            s1 = bus.page_btn;
            if (evt) m_page = (m_page + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", 32'(bus.seg), 32'(exp_seg));
            check("model_an", 32'(bus.an), 32'(exp_an));
            check("model_page", 32'(bus.page), 32'(m_page));
        end
    end

    task automatic press();
        bus.page_btn = 1'b1;
        repeat (20) @(negedge clk);
        bus.page_btn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_scan_start();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = bus.an;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.an == 4'b1110 && prev == 4'b0111) found = 1;
            prev = bus.an;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scan_timeout: got no scan start expected one within 200 clocks");
        end
    endtask

    vec_t vecs [6];

    initial begin
        int exp_pg;
        logic [3:0] e_an;

        vecs[0] = '{0, 16'h1A2F, 16'h0000, 4'h0, 8'h00, {8'hF9, 8'h88, 8'hA4, 8'h0E}};
        vecs[1] = '{0, 16'h0000, 16'h1234, 4'h1, 8'h11, {8'hC0, 8'hC0, 8'hC0, 8'h40}};
        vecs[2] = '{1, 16'h5555, 16'hBEEF, 4'h2, 8'h22, {8'h83, 8'h86, 8'h06, 8'h8E}};
        vecs[3] = '{2, 16'h6666, 16'h7777, 4'h5, 8'hC3, {8'hC0, 8'h12, 8'hC6, 8'hB0}};
        vecs[4] = '{2, 16'h6666, 16'h7777, 4'hA, 8'hD9, {8'hC0, 8'h08, 8'hA1, 8'h90}};
        vecs[5] = '{0, 16'h8476, 16'h9999, 4'h3, 8'h44, {8'h80, 8'h99, 8'hF8, 8'h02}};

        bus.page_btn = 1'b0; bus.pc = 16'h0; bus.insn = 16'h0;
        bus.state = 4'h0; bus.outport = 8'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_seg", 32'(bus.seg), 32'hFF);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_page", 32'(bus.page), 32'h0);

        reset = 1'b0;
        @(negedge clk);
        check("first_an", 32'(bus.an), 32'hE);
        check("first_seg", 32'(bus.seg), 32'h40);
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            e_an = 4'hF;
            e_an[(k + 1) % 4] = 1'b0;
            check("an_step", 32'(bus.an), 32'(e_an));
        end

        // short glitch, then a long hold that must step the page exactly once
        bus.page_btn = 1'b1;
        repeat (5) @(negedge clk);
        bus.page_btn = 1'b0;
        repeat (30) @(negedge clk);
`ifdef SSD_DEBOUNCE_EN
        exp_pg = 0;
`else
        exp_pg = 1;
`endif
        check("pulse_page", 32'(bus.page), 32'(exp_pg));
        bus.page_btn = 1'b1;
        repeat (20) @(negedge clk);
        exp_pg = (exp_pg + 1) % 3;
        check("hold_page", 32'(bus.page), 32'(exp_pg));
        repeat (20) @(negedge clk);
        check("hold_once", 32'(bus.page), 32'(exp_pg));
        bus.page_btn = 1'b0;
        repeat (20) @(negedge clk);

        foreach (vecs[i]) begin
            for (int k = 0; k < 3 && m_page != vecs[i].pg; k++) press();
            check("vec_page", 32'(bus.page), 32'(vecs[i].pg));
            bus.pc = vecs[i].pc; bus.insn = vecs[i].insn;
            bus.state = vecs[i].st; bus.outport = vecs[i].op;
            wait_scan_start();
            wait_scan_start();
            for (int dd = 0; dd < 4; dd++) begin
                check("vec_seg", 32'(bus.seg), 32'(vecs[i].exp_seg[dd]));
                repeat (4) @(negedge clk);
            end
        end

        // pc change in the middle of a scan must not disturb the digits on show
        bus.pc = 16'h1111;
        wait_scan_start();
        wait_scan_start();
        repeat (5) @(negedge clk);
        bus.pc = 16'h2222;
        repeat (3) @(negedge clk);
        check("midscan_old", 32'(bus.seg), 32'hF9);
        wait_scan_start();
        check("midscan_new", 32'(bus.seg), 32'h24);

        // reset mid-scan while on page 2
        for (int k = 0; k < 3 && m_page != 2; k++) press();
        check("pre_rst_page", 32'(bus.page), 32'h2);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_seg", 32'(bus.seg), 32'hFF);
        check("mid_rst_an", 32'(bus.an), 32'hF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_an", 32'(bus.an), 32'hE);
        check("post_rst_seg", 32'(bus.seg), 32'h40);
        check("post_rst_page", 32'(bus.page), 32'h0);

        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) bus.pc = 16'($urandom);
                if ($urandom_range(0, 7) == 0) bus.insn = 16'($urandom);
                if ($urandom_range(0, 7) == 0) bus.state = 4'($urandom);
                if ($urandom_range(0, 7) == 0) bus.outport = 8'($urandom);
                if (hold == 0) begin
                    bus.page_btn = 1'($urandom);
                    hold = int'($urandom_range(1, 25));
                end else begin
                    hold = hold - 1;
                end
                reset = ($urandom_range(0, 499) == 0);
            end
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
